mem_port_arbiter: RTL and testbench

Shares one single-ported unified instruction/data memory between the instruction-fetch path and the load/store path of the RISC-V core. It grants one requester at a time and drives the memory port with word-aligned address, byte enables and lane-replicated write data. It returns read data or a write acknowledge after a fixed, parameterised memory latency. It sits between the Controller-driven datapath (MemWrite encoding 00 none/read, 01 word, 10 half, 11 byte) and the memory macro.

---
 rtl/mem_port_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified instruction/data memory between the
// instruction-fetch path and the load/store path. One requester is granted
// at a time. The memory sees a word-aligned address, byte-lane enables and
// lane-replicated store data. Read data (or a write acknowledge) returns
// MEM_LAT cycles after the memory strobe.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate between the
// requesters on simultaneous requests. Without it, data has fixed priority
// over fetch.
//
// Ports
//   clk, reset                : clock, synchronous active-high reset
//   if_req/if_addr            : fetch request (always a word read)
//   if_gnt/if_rvalid/if_rdata : fetch grant, response pulse, fetched word
//   d_req/d_addr/d_we/d_wdata : data request (d_we: 00 rd, 01 word, 10 half, 11 byte)
//   d_gnt/d_rvalid/d_rdata    : data grant, response pulse, read word (0 for writes)
//   d_err                     : misaligned-access flag, pulses with d_rvalid
//   mem_en/mem_we/mem_be      : memory strobe, write strobe, byte enables
//   mem_addr/mem_wdata        : word-aligned address, replicated write data
//   mem_rdata                 : memory read data
module mem_port_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0] state_r;
    logic [3:0] cnt_r;
    logic       owner_d_r;
    logic       err_r;
    logic       wr_r;

    // Byte-lane enables for a data access.
    function automatic logic [3:0] calc_be(input logic [1:0] we, input logic [1:0] a);
        case (we)
            2'b10:   calc_be = 4'b0011 << {a[1], 1'b0};
            2'b11:   calc_be = 4'b0001 << a;
            default: calc_be = 4'b1111;
        endcase
    endfunction

    // Store data replicated across the lanes; reads drive zero.
    function automatic logic [31:0] calc_wdata(input logic [1:0] we, input logic [31:0] wd);
        case (we)
            2'b01:   calc_wdata = wd;
            2'b10:   calc_wdata = {2{wd[15:0]}};
            2'b11:   calc_wdata = {4{wd[7:0]}};
            default: calc_wdata = 32'h0000_0000;
        endcase
    endfunction

    // Word accesses need addr[1:0]==0, half writes need addr[0]==0.
    function automatic logic calc_misaligned(input logic [1:0] we, input logic [1:0] a);
        case (we)
            2'b00,
            2'b01:   calc_misaligned = (a != 2'b00);
            2'b10:   calc_misaligned = a[0];
            default: calc_misaligned = 1'b0;
        endcase
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_r;  // 1: data was granted last, 0: fetch

    // Remember the last owner so simultaneous requests alternate.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_d_r <= 1'b0;
        end else if (d_gnt) begin
            last_d_r <= 1'b1;
        end else if (if_gnt) begin
            last_d_r <= 1'b0;
        end else begin
            last_d_r <= last_d_r;
        end
    end
`endif

    // Combinational grant: only in IDLE, only outside reset, at most one.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!reset && (state_r == S_IDLE)) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (d_req && if_req) begin
                d_gnt  = !last_d_r;
                if_gnt = last_d_r;
            end else begin
                d_gnt  = d_req;
                if_gnt = if_req;
            end
`else
            d_gnt  = d_req;
            if_gnt = if_req && !d_req;
`endif
        end else begin
            if_gnt = 1'b0;
            d_gnt  = 1'b0;
        end
    end

    // Access sequencer: grant capture, memory strobe, latency count, response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            cnt_r     <= 4'd0;
            owner_d_r <= 1'b0;
            err_r     <= 1'b0;
            wr_r      <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= 32'h0000_0000;
            d_rvalid  <= 1'b0;
            d_rdata   <= 32'h0000_0000;
            d_err     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
        end else begin
            // Memory-side outputs and response pulses last exactly one cycle.
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (d_gnt) begin
                        state_r   <= S_ISSUE;
                        owner_d_r <= 1'b1;
                        err_r     <= calc_misaligned(d_we, d_addr[1:0]);
                        wr_r      <= (d_we != 2'b00);
                        mem_en    <= 1'b1;
                        mem_we    <= (d_we != 2'b00);
                        mem_be    <= calc_be(d_we, d_addr[1:0]);
                        mem_addr  <= d_addr & 32'hFFFF_FFFC;
                        mem_wdata <= calc_wdata(d_we, d_wdata);
                    end else if (if_gnt) begin
                        state_r   <= S_ISSUE;
                        owner_d_r <= 1'b0;
                        err_r     <= 1'b0;
                        wr_r      <= 1'b0;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_be    <= 4'b1111;
                        mem_addr  <= if_addr & 32'hFFFF_FFFC;
                        mem_wdata <= 32'h0000_0000;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    state_r <= S_WAIT;
                    cnt_r   <= 4'(MEM_LAT - 1);
                end
                S_WAIT: begin
                    // Last WAIT cycle: memory data is valid, capture it for the owner.
                    if (cnt_r == 4'd0) begin
                        state_r <= S_RESP;
                        if (owner_d_r) begin
                            d_rvalid <= 1'b1;
                            d_err    <= err_r;
                            d_rdata  <= wr_r ? 32'h0000_0000 : mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                S_RESP: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [1:0]  d_we;

    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, d_err1, mem_en1, mem_we1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
    logic [3:0]  mem_be1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1),
        .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1), .d_err(d_err1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_be(mem_be1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        is_d;
        logic [1:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_we;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        vec_t        v;
        logic [31:0] prev_if, prev_d;
        logic [3:0]  exp_order;
        int          gcyc[4];
        logic        gown[4];
        int          ng, both, viol, d_seen, if_seen;
        logic        prev_en;

        //               is_d we     addr          wdata         mrd           e_addr        e_be    e_wdata       e_we  e_rdata       e_err
        vecs[0] = '{1'b0, 2'b00, 32'h0000_0100, 32'h0,        32'h0050_0093, 32'h0000_0100, 4'hF, 32'h0,        1'b0, 32'h0050_0093, 1'b0};
        vecs[1] = '{1'b1, 2'b11, 32'h0000_0203, 32'h0000_00AB, 32'hDEAD_BEEF, 32'h0000_0200, 4'h8, 32'hABAB_ABAB, 1'b1, 32'h0,         1'b0};
        vecs[2] = '{1'b1, 2'b10, 32'h0000_0201, 32'h0000_1234, 32'h5555_5555, 32'h0000_0200, 4'h3, 32'h1234_1234, 1'b1, 32'h0,         1'b1};
        vecs[3] = '{1'b1, 2'b00, 32'h0000_0206, 32'h0,        32'hCAFE_F00D, 32'h0000_0204, 4'hF, 32'h0,        1'b0, 32'hCAFE_F00D, 1'b1};
        vecs[4] = '{1'b1, 2'b01, 32'h0000_0010, 32'h89AB_CDEF, 32'h0BAD_0BAD, 32'h0000_0010, 4'hF, 32'h89AB_CDEF, 1'b1, 32'h0,         1'b0};
        vecs[5] = '{1'b1, 2'b10, 32'h0000_0302, 32'hFFFF_5A5A, 32'h0,        32'h0000_0300, 4'hC, 32'h5A5A_5A5A, 1'b1, 32'h0,         1'b0};
        vecs[6] = '{1'b0, 2'b00, 32'h0000_0103, 32'h0,        32'h0000_0013, 32'h0000_0100, 4'hF, 32'h0,        1'b0, 32'h0000_0013, 1'b0};
        vecs[7] = '{1'b1, 2'b11, 32'h0000_0401, 32'h1234_5677, 32'h0,        32'h0000_0400, 4'h2, 32'h7777_7777, 1'b1, 32'h0,         1'b0};
        vecs[8] = '{1'b1, 2'b00, 32'h0000_0040, 32'h0,        32'h1122_3344, 32'h0000_0040, 4'hF, 32'h0,        1'b0, 32'h1122_3344, 1'b0};

        if_req = 1'b1; d_req = 1'b1; if_addr = 32'h0; d_addr = 32'h0;
        d_we = 2'b00; d_wdata = 32'h0; mem_rdata = 32'hFFFF_FFFF;

        // Reset state with both requests pending: nothing granted, all outputs zero.
        reset = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
        chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
        chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("rst_d_err", {31'd0, d_err}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        next_cycle();
        if_req = 1'b0; d_req = 1'b0; reset = 1'b0;

        // Table-driven single transactions (MEM_LAT=2).
        prev_if = 32'h0;
        prev_d  = 32'h0;
        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            mem_rdata = v.mrd;
            if (v.is_d) begin
                d_req = 1'b1; d_addr = v.addr; d_we = v.we; d_wdata = v.wdata;
            end else begin
                if_req = 1'b1; if_addr = v.addr;
            end
            @(negedge clk);  // T
            chk("gnt_owner", {31'd0, v.is_d ? d_gnt : if_gnt}, 32'd1);
            chk("gnt_other", {31'd0, v.is_d ? if_gnt : d_gnt}, 32'd0);
            next_cycle();
            if_req = 1'b0; d_req = 1'b0;
            @(negedge clk);  // T+1 ISSUE
            chk("issue_mem_en", {31'd0, mem_en}, 32'd1);
            chk("issue_mem_addr", mem_addr, v.e_addr);
            chk("issue_mem_be", {28'd0, mem_be}, {28'd0, v.e_be});
            chk("issue_mem_wdata", mem_wdata, v.e_wdata);
            chk("issue_mem_we", {31'd0, mem_we}, {31'd0, v.e_we});
            next_cycle();
            @(negedge clk);  // T+2
            chk("wait_mem_en", {31'd0, mem_en}, 32'd0);
            chk("wait_mem_addr", mem_addr, 32'd0);
            chk("wait_rvalid", {31'd0, if_rvalid | d_rvalid}, 32'd0);
            next_cycle();
            @(negedge clk);  // T+3
            chk("wait2_rvalid", {31'd0, if_rvalid | d_rvalid}, 32'd0);
            next_cycle();
            @(negedge clk);  // T+4 RESP
            if (v.is_d) begin
                chk("d_rvalid", {31'd0, d_rvalid}, 32'd1);
                chk("d_rdata", d_rdata, v.e_rdata);
                chk("d_err", {31'd0, d_err}, {31'd0, v.e_err});
                chk("if_rvalid_idle", {31'd0, if_rvalid}, 32'd0);
                chk("if_rdata_hold", if_rdata, prev_if);
                prev_d = v.e_rdata;
            end else begin
                chk("if_rvalid", {31'd0, if_rvalid}, 32'd1);
                chk("if_rdata", if_rdata, v.e_rdata);
                chk("d_rvalid_idle", {31'd0, d_rvalid}, 32'd0);
                chk("d_err_fetch", {31'd0, d_err}, 32'd0);
                chk("d_rdata_hold", d_rdata, prev_d);
                prev_if = v.e_rdata;
            end
            next_cycle();
        end

        // Reset during WAIT abandons the read; pending fetch granted right after reset.
        mem_rdata = 32'h0BAD_F00D;
        d_req = 1'b1; d_addr = 32'h0000_0040; d_we = 2'b00;
        @(negedge clk);
        chk("rw_d_gnt", {31'd0, d_gnt}, 32'd1);
        next_cycle();
        d_req = 1'b0;          // T+1 ISSUE
        next_cycle();
        reset = 1'b1;          // T+2 WAIT
        if_req = 1'b1; if_addr = 32'h0000_0100;
        @(negedge clk);
        chk("rw_gnt_in_reset", {31'd0, if_gnt}, 32'd0);
        next_cycle();
        reset = 1'b0;          // T+3 first cycle out of reset
        @(negedge clk);
        chk("rw_if_gnt_after", {31'd0, if_gnt}, 32'd1);
        chk("rw_no_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rw_no_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);        // fetch ISSUE
        chk("rw_fetch_en", {31'd0, mem_en}, 32'd1);
        chk("rw_fetch_addr", mem_addr, 32'h0000_0100);
        d_seen = 0; if_seen = 0;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            @(negedge clk);
            if (d_rvalid) d_seen++;
            if (if_rvalid) if_seen++;
        end
        chk("rw_d_rvalid_count", d_seen, 32'd0);
        chk("rw_if_rvalid_count", if_seen, 32'd1);
        next_cycle();

        // Both requesters held continuously from reset: grant order and spacing.
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = 4'b0101;   // bit k = grant k went to data: D,F,D,F
`else
        exp_order = 4'b1111;   // D,D,D,D
`endif
        if_req = 1'b1; d_req = 1'b1; d_we = 2'b00; d_addr = 32'h0; if_addr = 32'h0;
        do_reset();
        ng = 0; both = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (if_gnt && d_gnt) both++;
            if ((if_gnt || d_gnt) && ng < 4) begin
                gcyc[ng] = c;
                gown[ng] = d_gnt;
                ng++;
            end
            next_cycle();
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("arb_grant_count", ng, 32'd4);
        chk("arb_double_grant", both, 32'd0);
        chk("arb_first_cycle", gcyc[0], 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("arb_order", {31'd0, gown[k]}, {31'd0, exp_order[k]});
        end
        for (int k = 1; k < 4; k++) begin
            chk("arb_spacing", gcyc[k] - gcyc[k-1], 32'd5);
        end

        // MEM_LAT=1: back-to-back data reads on the second instance.
        d_req = 1'b1; d_we = 2'b00; d_addr = 32'h0000_0080;
        do_reset();
        ng = 0; viol = 0; prev_en = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (mem_en1 && prev_en) viol++;
            prev_en = mem_en1;
            if (d_gnt1 && ng < 4) begin
                gcyc[ng] = c;
                ng++;
            end
            next_cycle();
        end
        d_req = 1'b0;
        chk("lat1_grant_count", ng, 32'd4);
        chk("lat1_consec_mem_en", viol, 32'd0);
        for (int k = 1; k < 4; k++) begin
            chk("lat1_spacing", gcyc[k] - gcyc[k-1], 32'd4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
